// File: rtl/wbm_bytes_pkg.sv
// Shared types and constants for the byte-stream Wishbone master.
// Frame field positions, status codes and FSM state encoding.
package wbm_bytes_pkg;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADR_HI,
    S_ADR_LO,
    S_DATA,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] STATUS_OK  = 8'h00;
  localparam logic [7:0] STATUS_TMO = 8'hEE;

  localparam int CMD_WE_BIT  = 7;
  localparam int CMD_SEL_MSB = 3;
  localparam int CMD_SEL_LSB = 0;

  function automatic logic [2:0] resp_len(
    input logic we,
    input logic ok
  );
    return (ok && !we) ? 3'd5 : 3'd1;
  endfunction

endpackage

// File: rtl/wbm_bytes_if.sv
// Byte-stream command/response channels plus the Wishbone master bus.
// master = the wbm_bytes core, slave = host link and bus target.
interface wbm_bytes_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [15:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_stall_i;
  logic        wbm_ack_i;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    input  wbm_dat_i, wbm_stall_i, wbm_ack_i,
    output rx_ready, tx_data, tx_valid,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_adr_o, wbm_sel_o, wbm_dat_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    output wbm_dat_i, wbm_stall_i, wbm_ack_i,
    input  rx_ready, tx_data, tx_valid,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_adr_o, wbm_sel_o, wbm_dat_o
  );
endinterface

// File: rtl/wbm_bytes_ser.sv
// Response serializer: shifts out 1..5 bytes MSB first.
// tx_data is registered and only moves on a handshake.
module wbm_bytes_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  len,
  input  logic [39:0] bytes,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] rest;
  logic [2:0]  idx;
  logic [2:0]  last;

  assign done = tx_valid && tx_ready && (idx == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rest     <= 32'h0;
      idx      <= 3'd0;
      last     <= 3'd0;
    end else if (start) begin
      tx_data  <= bytes[39:32];
      rest     <= bytes[31:0];
      idx      <= 3'd0;
      last     <= len - 3'd1;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_data <= rest[31:24];
      rest    <= {rest[23:0], 8'h00};
      idx     <= idx + 3'd1;
      if (idx == last) tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wbm_bytes.sv
// Byte-stream driven Wishbone B4 pipelined master.
// One single-beat bus cycle per command frame, status+data back.
module wbm_bytes
  import wbm_bytes_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input logic         wb_clk_i,
  input logic         wb_rst_i,
  wbm_bytes_if.master bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t      state;
  logic        rx_ready;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] rdata;
  logic [7:0]  status;
  logic [CW-1:0] cnt;
  logic [1:0]  bcnt;
  logic        start;
  logic        done;
  logic        rx_hs;
  logic        ack_ok;
  logic        tmo;

  assign rx_hs = bus.rx_valid && rx_ready;
  // In REQ an ack only counts together with acceptance.
  assign ack_ok = (state == S_REQ)
                ? (!bus.wbm_stall_i && bus.wbm_ack_i)
                : bus.wbm_ack_i;
  assign tmo = (cnt == LAST);

  assign bus.rx_ready  = rx_ready;
  assign bus.wbm_cyc_o = cyc;
  assign bus.wbm_stb_o = stb;
  assign bus.wbm_we_o  = we;
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_sel_o = sel;
  assign bus.wbm_dat_o = dat_o;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= S_CMD;
      rx_ready <= 1'b0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      we       <= 1'b0;
      adr      <= 16'h0;
      sel      <= 4'h0;
      dat_o    <= 32'h0;
      rdata    <= 32'h0;
      status   <= 8'h00;
      cnt      <= '0;
      bcnt     <= 2'd0;
      start    <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        S_CMD: begin
          rx_ready <= 1'b1;
          if (rx_hs) begin
            we    <= bus.rx_data[CMD_WE_BIT];
            sel   <= bus.rx_data[CMD_SEL_MSB:CMD_SEL_LSB];
            state <= S_ADR_HI;
          end
        end
        S_ADR_HI: begin
          if (rx_hs) begin
            adr[15:8] <= bus.rx_data;
            state     <= S_ADR_LO;
          end
        end
        S_ADR_LO: begin
          if (rx_hs) begin
            adr[7:0] <= bus.rx_data;
            bcnt     <= 2'd0;
            if (we) begin
              state <= S_DATA;
            end else begin
              state    <= S_REQ;
              rx_ready <= 1'b0;
              cyc      <= 1'b1;
              stb      <= 1'b1;
              cnt      <= '0;
            end
          end
        end
        S_DATA: begin
          if (rx_hs) begin
            dat_o <= {dat_o[23:0], bus.rx_data};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state    <= S_REQ;
              rx_ready <= 1'b0;
              cyc      <= 1'b1;
              stb      <= 1'b1;
              cnt      <= '0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (ack_ok) begin
            cyc    <= 1'b0;
            stb    <= 1'b0;
            start  <= 1'b1;
            status <= STATUS_OK;
            state  <= S_RESP;
            if (!we) rdata <= bus.wbm_dat_i;
          end else if (tmo) begin
            cyc    <= 1'b0;
            stb    <= 1'b0;
            start  <= 1'b1;
            status <= STATUS_TMO;
            state  <= S_RESP;
          end else if (state == S_REQ && !bus.wbm_stall_i) begin
            stb   <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_RESP: begin
          if (done) begin
            state    <= S_CMD;
            rx_ready <= 1'b1;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

  wbm_bytes_ser u_ser (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .start    (start),
    .len      (resp_len(we, status == STATUS_OK)),
    .bytes    ({status, rdata}),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .tx_ready (bus.tx_ready),
    .done     (done)
  );

endmodule
